uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  UART 8N1 serial transmitter driving the SoC TXD pin (currently tied to 0).
//  Byte-wide valid/ready input from the core/MMIO side. LSB-first serial out, idle-high.
//  It is the transmit counterpart of the SoC RXD path and shares its line format and baud rate.
// PARAMETERS
//  CLK_FREQ_HZ   12_000_000  input clock frequency
//  BAUD_RATE     115_200     line rate
//  CLKS_PER_BIT  CLK_FREQ_HZ/BAUD_RATE (104)  cycles per bit
//                overridable directly; must be >= 2 (elaboration $error otherwise)
// PORTS
//  CLK       in   1  system clock, all state on posedge
//  RESET     in   1  asynchronous, active-high reset
//  tx_data   in   8  byte to send; sampled only on accept
//  tx_valid  in   1  request; hold until accepted
//  tx_ready  out  1  high when a byte can be accepted this cycle
//  tx_busy   out  1  high while a frame is on the line (START..STOP)
//  tx_done   out  1  one-cycle pulse at the end of each stop bit
//  TXD       out  1  serial line, idle 1
// BEHAVIOUR
//  Reset values: TXD=1, tx_busy=0, tx_done=0, tx_ready=1, state=IDLE, counters=0.
//  RESET forces TXD high immediately, mid-frame included. The aborted frame gets no tx_done.
//  Accept: tx_valid && tx_ready at a posedge. At that edge, latch tx_data into the shift register.
//  States: IDLE -> START -> DATA -> STOP -> IDLE, or STOP -> START on a back-to-back accept.
//   IDLE : TXD=1, tx_ready=1. On accept -> START.
//   START: TXD=0 for CLKS_PER_BIT cycles -> DATA.
//   DATA : TXD=shift[0] for CLKS_PER_BIT cycles per bit, then shift right.
//          bit index 0..7; after bit 7 -> STOP.
//   STOP : TXD=1 for CLKS_PER_BIT cycles.
//          On its last cycle: tx_done=1, tx_ready=1.
//          Accept on that cycle -> START, with no idle gap. Otherwise -> IDLE.
//  Latency: TXD falls on the first edge after the accepting edge.
//   A frame is exactly 10*CLKS_PER_BIT cycles.
//   tx_done is high in the last of them.
//  TXD is registered; no combinational path from inputs to TXD.
//  tx_ready is low in START/DATA and in STOP except its last cycle.
//   tx_valid/tx_data changes in that window are ignored; the frame in flight is unaffected.
//  Baud counter: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
//   Wraps to 0 on every bit boundary and on accept. Never reaches CLKS_PER_BIT.
//  Bit index: 3 bits, wraps to 0 on leaving DATA.
//  tx_busy = (state != IDLE); it stays 1 across a back-to-back STOP->START.
// STRUCTURE
//  Package uart_pkg:
//   typedef enum logic [1:0] {UART_IDLE, UART_START, UART_DATA, UART_STOP} uart_state_t;
//   localparam UART_DATA_BITS = 8.
//   Shared with the future uart_rx.
//  Sub-module uart_baud_gen (CLKS_PER_BIT):
//   inputs clear and enable; output bit_tick on the last cycle of each bit period.
//   Reused by uart_rx.
//  uart_tx holds the FSM, the shift register and the bit index.
// TESTING (CLKS_PER_BIT=4 unless noted)
//  1. Reset, no traffic:
//     RESET pulse, tx_valid=0 for 100 cycles -> TXD=1, tx_ready=1, tx_busy=0, tx_done never 1.
//  2. Single byte:
//     tx_data=8'h55 accepted at edge T -> TXD 0 for T+1..T+4.
//     Then data bits 1,0,1,0,1,0,1,0 for 4 cycles each; stop 1 for T+37..T+40.
//     tx_done=1 only at T+40. tx_ready=0 T+1..T+39, 1 at T+40.
//  3. Back-to-back: tx_valid held with 8'hA3 then 8'h0F ->
//     second start bit begins at T+41, no idle cycle between frames.
//     Line bits: 0,11000101,1,0,11110000,1. tx_busy stays 1 throughout.
//  4. Ignore while busy:
//     at T+10 present tx_valid=1, tx_data=8'hFF, removed at T+20 -> frame still sends 8'h55.
//     No second frame is sent.
//  5. Reset mid-frame:
//     assert RESET during DATA bit 3 -> TXD=1 asynchronously and no tx_done.
//     After release, tx_ready=1; a new 8'h3C then transmits correctly.
//  6. Default parameters (104):
//     send 8'h00 -> low period of 9*104 cycles, then 104 high.
//     The uart_rx model decodes 8'h00.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state encoding and frame geometry.
// Used by uart_tx now and by the future uart_rx.
package uart_pkg;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_IDX_W     = 3;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer shared by the UART transmitter and receiver.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : restart the bit period at count 0 (wins over enable)
//   enable    : advance the count while a frame is in progress
//   bit_tick  : high during the last cycle of each bit period
//   cnt       : current position inside the bit period, 0..CLKS_PER_BIT-1
module uart_baud_gen #(
  parameter  int unsigned CLKS_PER_BIT = 104,
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic             bit_tick,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_baud_gen: CLKS_PER_BIT must be >= 2");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Count wraps at the bit boundary; tick is registered alongside so it
  // is high exactly while the count sits at its last value.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign bit_tick = tick_q;
  assign cnt      = cnt_q;

endmodule

// File: rtl/uart_tx.sv
// UART 8N1 transmitter: byte-wide valid/ready in, LSB-first serial out, idle high.
// Ports:
//   CLK, RESET : clock, asynchronous active-high reset
//   tx_data    : byte to send, captured on accept (tx_valid && tx_ready)
//   tx_valid   : request, held until accepted
//   tx_ready   : a byte can be accepted at the coming edge
//   tx_busy    : a frame is on the line
//   tx_done    : one-cycle pulse during the last stop-bit cycle
//   TXD        : registered serial line
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 12_000_000,
  parameter int unsigned BAUD_RATE    = 115_200,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic                      tx_busy,
  output logic                      tx_done,
  output logic                      TXD
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]      PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [UART_IDX_W-1:0] LAST_IDX = UART_IDX_W'(UART_DATA_BITS - 1);

  uart_state_t               state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                      txd_q, txd_d;
  logic                      ready_q, ready_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic             accept;
  logic             baud_clear;
  logic             baud_en;
  logic             bit_tick;
  logic [CNT_W-1:0] baud_cnt;

  assign accept     = tx_valid && ready_q;
  assign baud_clear = accept;
  assign baud_en    = (state_q != UART_IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (CLK),
    .rst      (RESET),
    .clear    (baud_clear),
    .enable   (baud_en),
    .bit_tick (bit_tick),
    .cnt      (baud_cnt)
  );

  // Next-state and next-output logic; TXD is computed one cycle ahead so the
  // line is driven straight from a flop.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    txd_d     = txd_q;
    ready_d   = ready_q;
    done_d    = 1'b0;

    unique case (state_q)
      UART_IDLE: begin
        txd_d   = 1'b1;
        ready_d = 1'b1;
        if (accept) begin
          state_d = UART_START;
          shift_d = tx_data;
          txd_d   = 1'b0;
          ready_d = 1'b0;
        end
      end
      UART_START: begin
        if (bit_tick) begin
          state_d   = UART_DATA;
          txd_d     = shift_q[0];
          bit_idx_d = '0;
        end
      end
      UART_DATA: begin
        if (bit_tick) begin
          if (bit_idx_q == LAST_IDX) begin
            state_d   = UART_STOP;
            txd_d     = 1'b1;
            bit_idx_d = '0;
          end else begin
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
            bit_idx_d = bit_idx_q + UART_IDX_W'(1);
          end
        end
      end
      UART_STOP: begin
        // Raise done/ready one edge early so both are visible in the last stop cycle.
        if (!bit_tick && baud_cnt == PRE_LAST) begin
          done_d  = 1'b1;
          ready_d = 1'b1;
        end
        if (bit_tick) begin
          if (accept) begin
            state_d = UART_START;
            shift_d = tx_data;
            txd_d   = 1'b0;
            ready_d = 1'b0;
          end else begin
            state_d = UART_IDLE;
            txd_d   = 1'b1;
            ready_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = UART_IDLE;
        txd_d   = 1'b1;
        ready_d = 1'b1;
      end
    endcase

    busy_d = (state_d != UART_IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= UART_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign TXD      = txd_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed and random bytes against a line-level frame model.
module tb_uart_tx;

  localparam int CPB  = 4;
  localparam int CPB2 = 104;
  localparam int FRAME  = 10 * CPB;
  localparam int FRAME2 = 10 * CPB2;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       ready, busy, done, txd;
  logic [7:0] tx_data2;
  logic       tx_valid2;
  logic       ready2, busy2, done2, txd2;

  int checks   = 0;
  int failures = 0;

  logic       line2 [0:FRAME2-1];

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .CLK      (clk),
    .RESET    (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (ready),
    .tx_busy  (busy),
    .tx_done  (done),
    .TXD      (txd)
  );

  uart_tx dut_default (
    .CLK      (clk),
    .RESET    (rst),
    .tx_data  (tx_data2),
    .tx_valid (tx_valid2),
    .tx_ready (ready2),
    .tx_busy  (busy2),
    .tx_done  (done2),
    .TXD      (txd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level i cycles after the accepting edge: start, 8 data LSB-first, stop.
  function automatic logic line_bit(input logic [7:0] b, input int i, input int cpb);
    int         idx;
    logic [7:0] sh;
    idx = i / cpb;
    if (idx == 0) return 1'b0;
    if (idx > 8)  return 1'b1;
    sh = b >> (idx - 1);
    return sh[0];
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      chk("idle_txd", txd, 1'b1);
      chk("idle_busy", busy, 1'b0);
      chk("idle_ready", ready, 1'b1);
      chk("idle_done", done, 1'b0);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    chk("accept_ready", ready, 1'b1);
    tx_data  = b;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
  endtask

  // Called just after the accepting edge; ends in the last stop-bit cycle.
  // ign_on/ign_off drive a junk request while the frame is in flight.
  task automatic expect_frame(input logic [7:0] b, input int ign_on, input int ign_off);
    for (int i = 0; i < FRAME; i++) begin
      if (i == ign_on)  begin tx_valid = 1'b1; tx_data = 8'hFF; end
      if (i == ign_off) begin tx_valid = 1'b0; tx_data = 8'h00; end
      chk("frame_txd", txd, line_bit(b, i, CPB));
      chk("frame_done", done, (i == FRAME - 1));
      chk("frame_ready", ready, (i == FRAME - 1));
      chk("frame_busy", busy, 1'b1);
      if (i < FRAME - 1) step();
    end
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] rx_byte;
    int         low_run;
    int         high_cnt;
    int         done_cnt;

    rst       = 1'b1;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    tx_valid2 = 1'b0;
    tx_data2  = 8'h00;
    #1;
    chk("rst_txd", txd, 1'b1);
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    step();
    step();
    step();
    rst = 1'b0;

    // Quiet line after reset
    idle_check(100);

    // Single byte 0x55
    send_byte(8'h55);
    expect_frame(8'h55, -1, -1);
    idle_check(3);

    // Random bytes with random idle gaps
    for (int n = 0; n < 4; n++) begin
      b = 8'($urandom);
      send_byte(b);
      expect_frame(b, -1, -1);
      idle_check(int'($urandom_range(1, 5)));
    end

    // Back-to-back frames with tx_valid held
    chk("b2b_ready", ready, 1'b1);
    tx_data  = 8'hA3;
    tx_valid = 1'b1;
    step();
    tx_data  = 8'h0F;
    expect_frame(8'hA3, -1, -1);
    step();
    tx_valid = 1'b0;
    expect_frame(8'h0F, -1, -1);
    idle_check(5);

    // Requests while busy are ignored
    send_byte(8'h55);
    expect_frame(8'h55, 9, 19);
    idle_check(45);

    // Reset in the middle of data bit 3
    b = 8'($urandom);
    send_byte(b);
    for (int i = 0; i < 17; i++) step();
    chk("pre_rst_txd", txd, line_bit(b, 17, CPB));
    chk("pre_rst_busy", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_txd", txd, 1'b1);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_ready", ready, 1'b1);
    chk("async_rst_done", done, 1'b0);
    step();
    chk("held_rst_txd", txd, 1'b1);
    chk("held_rst_done", done, 1'b0);
    step();
    rst = 1'b0;
    idle_check(45);
    send_byte(8'h3C);
    expect_frame(8'h3C, -1, -1);
    idle_check(2);

    // Default divider: 0x00 on the 104-cycle instance, decoded by a sampling receiver model
    chk("def_ready", ready2, 1'b1);
    tx_data2  = 8'h00;
    tx_valid2 = 1'b1;
    step();
    tx_valid2 = 1'b0;
    done_cnt  = 0;
    for (int i = 0; i < FRAME2; i++) begin
      line2[i] = txd2;
      if (done2 === 1'b1) done_cnt++;
      if (i < FRAME2 - 1) step();
    end
    chk("def_done_last", done2, 1'b1);
    chk32("def_done_count", done_cnt, 1);
    low_run = FRAME2;
    for (int i = FRAME2 - 1; i >= 0; i--) begin
      if (line2[i] === 1'b1) low_run = i;
    end
    high_cnt = 0;
    for (int i = 9 * CPB2; i < FRAME2; i++) begin
      if (line2[i] === 1'b1) high_cnt++;
    end
    chk32("def_low_run", low_run, 9 * CPB2);
    chk32("def_high_run", high_cnt, CPB2);
    for (int k = 0; k < 8; k++) rx_byte[k] = line2[(k + 1) * CPB2 + CPB2 / 2];
    chk("def_rx_start", line2[CPB2 / 2], 1'b0);
    chk("def_rx_stop", line2[9 * CPB2 + CPB2 / 2], 1'b1);
    chk32("def_rx_byte", int'(rx_byte), 0);
    step();
    chk("def_idle_txd", txd2, 1'b1);
    chk("def_idle_busy", busy2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
